// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared constants and elaboration helpers for the up/down counter
package ctr_pkg;

   localparam int CTR_MODE_WRAP = 0;
   localparam int CTR_MODE_SAT  = 1;

   function automatic bit ctr_width_ok(input int width);
      return width >= 2;
   endfunction

   function automatic bit ctr_mode_ok(input int mode);
      return (mode == CTR_MODE_WRAP) || (mode == CTR_MODE_SAT);
   endfunction

endpackage

// File: rtl/ctr_next_calc.sv
// rtl/ctr_next_calc.sv - combinational next-count and bound-event decode
module ctr_next_calc
   import ctr_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int SAT_MODE = CTR_MODE_WRAP
) (
   input  logic [WIDTH-1:0] cq_i,
   input  logic [WIDTH-1:0] max_i,
   input  logic             up_dn,
   output logic [WIDTH-1:0] next_o,
   output logic             bound_o
);

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   always_comb begin
      next_o  = cq_i;
      bound_o = 1'b0;
      if (up_dn) begin
         // >= rather than == so a count left above a lowered max_i still hits the bound
         if (cq_i < max_i) begin
            next_o = cq_i + ONE;
         end else begin
            bound_o = 1'b1;
            next_o  = (SAT_MODE == CTR_MODE_SAT) ? max_i : ZERO;
         end
      end else begin
         if (cq_i != ZERO) begin
            next_o = cq_i - ONE;
         end else begin
            bound_o = 1'b1;
            next_o  = (SAT_MODE == CTR_MODE_SAT) ? ZERO : max_i;
         end
      end
   end

endmodule

// File: rtl/sync_updn_counter.sv
// rtl/sync_updn_counter.sv - synchronous up/down counter with load, programmable max and flags
module sync_updn_counter
   import ctr_pkg::*;
#(
   parameter int               WIDTH    = 4,
   parameter int               SAT_MODE = CTR_MODE_WRAP,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] d_i,
   input  logic [WIDTH-1:0] max_i,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] cqo,
   output logic             tc_o,
   output logic             wrap_o,
   output logic             ovf_o
);

   if (!ctr_width_ok(WIDTH)) begin : g_bad_width
      $error("sync_updn_counter: WIDTH must be at least 2");
   end
   if (!ctr_mode_ok(SAT_MODE)) begin : g_bad_mode
      $error("sync_updn_counter: SAT_MODE must be 0 or 1");
   end

   logic [WIDTH-1:0] cq_q, cq_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] calc_next;
   logic             calc_bound;
   logic [WIDTH-1:0] load_val;
   logic             bound_evt;

   ctr_next_calc #(
      .WIDTH    (WIDTH),
      .SAT_MODE (SAT_MODE)
   ) u_next (
      .cq_i    (cq_q),
      .max_i   (max_i),
      .up_dn   (up_dn),
      .next_o  (calc_next),
      .bound_o (calc_bound)
   );

   assign load_val  = (d_i > max_i) ? max_i : d_i;
   assign bound_evt = ~load & en & calc_bound;

   always_comb begin
      cq_d   = cq_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (load) begin
         cq_d = load_val;
      end else if (en) begin
         cq_d = calc_next;
      end
      wrap_d = bound_evt;
      // set has priority over a same-cycle clear
      if (clr_ovf) begin
         ovf_d = 1'b0;
      end
      if (bound_evt) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cq_q   <= RST_VAL;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cq_q   <= cq_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign cqo    = cq_q;
   assign wrap_o = wrap_q;
   assign ovf_o  = ovf_q;
   assign tc_o   = en & ((up_dn & (cq_q >= max_i)) | (~up_dn & (cq_q == '0)));

endmodule

// File: doc/sync_updn_counter.md
Name: sync_updn_counter

Overview:
- Parametrised synchronous successor to the team's 4-bit ripple up-counter: all bits update on one clock edge, so there is no ripple skew.
- Adds up/down counting, a programmable maximum, parallel load, count enable, wrap or saturate mode, terminal-count and wrap flags, and a sticky overflow flag.
- Used as a general event/timer counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- SAT_MODE, 0, 0 = wrap at bounds, 1 = saturate at bounds.
- RST_VAL, 0, value loaded into cqo on reset; must be <= max_i in use.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; no effect when low, except load and clr_ovf.
- up_dn  input  1  1 = count up, 0 = count down; sampled only with en.
- load  input  1  parallel load request.
- d_i  input  WIDTH  parallel load value.
- max_i  input  WIDTH  upper count bound; the range is 0..max_i.
- clr_ovf  input  1  clears the sticky overflow flag.
- cqo  output  WIDTH  current count (registered).
- tc_o  output  1  terminal count: combinational decode of registered state.
- wrap_o  output  1  one-cycle registered pulse, bound event.
- ovf_o  output  1  sticky overflow/underflow flag.

Behaviour:
- Interface: one clock domain, clk. reset is synchronous, active-high, sampled on the rising edge of clk only.
- Reset values: cqo = RST_VAL, wrap_o = 0, ovf_o = 0.
- Priority on each edge: reset > load > en. clr_ovf is handled independently, as described below.
- Load: cqo <= min(d_i, max_i), with the clamp applied combinationally. Load does not assert wrap_o and does not change ovf_o.
- Count, en=1 and up_dn=1:
  - If cqo < max_i: cqo <= cqo+1.
  - Else (cqo >= max_i): a bound event. SAT_MODE=0 gives cqo <= 0. SAT_MODE=1 gives cqo <= max_i.
- Count, en=1 and up_dn=0:
  - If cqo > 0: cqo <= cqo-1.
  - Else (cqo == 0): a bound event. SAT_MODE=0 gives cqo <= max_i. SAT_MODE=1 gives cqo <= 0.
- Latency: cqo reflects an en/load/reset input one cycle after it is sampled.
- Arithmetic: no WIDTH+1 carry is stored; the comparisons are unsigned WIDTH-bit.
- wrap_o: equals 1 in the cycle after a bound event, otherwise 0. It pulses even in SAT_MODE.
- ovf_o:
  - Set on a bound event.
  - Cleared by clr_ovf when no bound event occurs in the same cycle.
  - Simultaneous set and clr_ovf: the set wins.
  - Load with a bound-free cycle leaves ovf_o unchanged.
- tc_o = en & ((up_dn & cqo >= max_i) | (~up_dn & cqo == 0)). It predicts a bound event at the next edge. It is the only combinational output.
- max_i changes dynamically: if cqo > max_i while counting up, the next enabled edge is a bound event. Counting down from cqo > max_i decrements normally.
- max_i = 0: counting is stuck at 0. Every enabled edge is a bound event (wrap: 0 -> 0).
- Reset mid-count: the count is abandoned, there is no wrap_o pulse, and the ovf_o history is lost.
- Load and en both high: load wins, with no bound event in that cycle.

Decomposition:
- Shared package ctr_pkg holds:
  - the constants CTR_MODE_WRAP=0 and CTR_MODE_SAT=1;
  - localparam-style helpers for width checks.
- One natural sub-module, ctr_next_calc, is purely combinational. Inputs: cqo, max_i, up_dn, SAT_MODE. Outputs: next count and the bound-event flag.
- The top module holds the registers, the priority mux and the flag logic.

Test Plan (WIDTH=4, RST_VAL=0):
1. SAT_MODE=0, max_i=9, up, en=1 for 12 cycles. Required: cqo runs 1..9, 0, 1, 2. wrap_o pulses once, the cycle cqo=0. tc_o is high while cqo=9. ovf_o=1 after that and stays set.
2. SAT_MODE=0, max_i=15, down from 0 for 2 cycles. Required: cqo runs 15, 14. wrap_o pulses with cqo=15. ovf_o=1. Then clr_ovf=1 for one cycle gives ovf_o=0.
3. SAT_MODE=1, max_i=5, up for 8 cycles. Required: cqo sticks at 5 after 5 edges. wrap_o pulses on each of the 3 blocked edges. Then down 7 cycles: cqo holds at 0 and wrap_o pulses twice.
4. Load d_i=12 with max_i=9, together with en=1 and up=1. Required: cqo=9 (clamped), no wrap_o. The next edge up wraps to 0 with a wrap_o pulse.
5. Bound event and clr_ovf in the same cycle. Required: ovf_o stays 1.
6. Count to 7, then assert reset with en=1 and load=1. Required: cqo=0, wrap_o=0, ovf_o=0 on the next edge. Counting then resumes at 1.
